// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined RV32I control unit.
// Opcode constants, control enums, the per-stage control structs and a few
// small decode/forwarding helpers used by the decoder and the top level.
package ctrl_pkg;

  localparam int RIDX_W = 5;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,  ALU_XOR    = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,  ALU_AND    = 5'd9,  ALU_PASSB  = 5'd10, ALU_RSV11  = 5'd11,
    ALU_RSV12  = 5'd12, ALU_RSV13  = 5'd13, ALU_MUL    = 5'd14, ALU_MULH   = 5'd15,
    ALU_MULHSU = 5'd16, ALU_MULHU  = 5'd17
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM, RES_PC4, RES_PCIMM} result_src_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM, PC_RS1IMM} pc_src_e;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_WB, FWD_MEM} fwd_e;

  typedef struct packed {
    logic              RegWrite;
    logic              MemWrite;
    logic              ALUsrc;
    alu_op_e           ALUctrl;
    result_src_e       ResultSrc;
    imm_src_e          ImmSrc;
    logic              branch;
    logic              jump;
    logic              jalr;
    logic              illegal;
    logic [2:0]        funct3;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } ctrl_t;

  // MEM and WB only carry what those stages still consume
  typedef struct packed {
    logic              RegWrite;
    logic              MemWrite;
    result_src_e       ResultSrc;
    logic [2:0]        funct3;
    logic [RIDX_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic              RegWrite;
    result_src_e       ResultSrc;
    logic [RIDX_W-1:0] rd;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Base integer ALU op shared by R and I types; alt selects SUB/SRA
  function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // MEM result is younger than WB, so it wins
  function automatic fwd_e fwd_sel(input logic use_rs, input logic [RIDX_W-1:0] rs,
                                   input logic mem_we, input logic [RIDX_W-1:0] mem_rd,
                                   input logic wb_we, input logic [RIDX_W-1:0] wb_rd);
    if (use_rs && mem_we && mem_rd != '0 && mem_rd == rs) return FWD_MEM;
    if (use_rs && wb_we && wb_rd != '0 && wb_rd == rs)    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decoder: instruction word -> ctrl_t.
// Ports: instr_i (32-bit instruction), ctrl_o (decoded control bundle).
// Any unknown opcode or funct field decodes to a bubble with illegal set.
module control_decoder
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;
  logic       ill;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  always_comb begin
    c        = CTRL_BUBBLE;
    ill      = 1'b0;
    c.funct3 = f3;
    c.rd     = instr_i[11:7];
    c.rs1    = instr_i[19:15];
    c.rs2    = instr_i[24:20];
    case (op)
      OP_R: begin
        c.RegWrite = 1'b1;
        c.use_rs1  = 1'b1;
        c.use_rs2  = 1'b1;
        case (f7)
          7'h00: c.ALUctrl = base_alu(f3, 1'b0);
          7'h20: begin
            if (f3 == 3'd0 || f3 == 3'd5) c.ALUctrl = base_alu(f3, 1'b1);
            else                          ill = 1'b1;
          end
          7'h01: begin
            if (SUPPORT_M && !f3[2]) begin
              case (f3[1:0])
                2'd0:    c.ALUctrl = ALU_MUL;
                2'd1:    c.ALUctrl = ALU_MULH;
                2'd2:    c.ALUctrl = ALU_MULHSU;
                default: c.ALUctrl = ALU_MULHU;
              endcase
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      OP_I: begin
        c.RegWrite = 1'b1;
        c.use_rs1  = 1'b1;
        c.ALUsrc   = 1'b1;
        c.ALUctrl  = base_alu(f3, f3 == 3'd5 && f7[5]);
        // shift-immediates carry funct7 in the immediate field
        if (f3 == 3'd1 && f7 != 7'h00)                  ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)   ill = 1'b1;
      end
      OP_LOAD: begin
        c.RegWrite  = 1'b1;
        c.use_rs1   = 1'b1;
        c.ALUsrc    = 1'b1;
        c.ResultSrc = RES_MEM;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ill = 1'b1;
      end
      OP_STORE: begin
        c.MemWrite = 1'b1;
        c.use_rs1  = 1'b1;
        c.use_rs2  = 1'b1;
        c.ALUsrc   = 1'b1;
        c.ImmSrc   = IMM_S;
        c.rd       = '0;
        if (f3 > 3'd2) ill = 1'b1;
      end
      OP_BRANCH: begin
        c.branch  = 1'b1;
        c.use_rs1 = 1'b1;
        c.use_rs2 = 1'b1;
        c.ALUctrl = ALU_SUB;
        c.ImmSrc  = IMM_B;
        c.rd      = '0;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      end
      OP_JAL: begin
        c.RegWrite  = 1'b1;
        c.jump      = 1'b1;
        c.ImmSrc    = IMM_J;
        c.ResultSrc = RES_PC4;
      end
      OP_JALR: begin
        c.RegWrite  = 1'b1;
        c.jalr      = 1'b1;
        c.use_rs1   = 1'b1;
        c.ALUsrc    = 1'b1;
        c.ResultSrc = RES_PC4;
        if (f3 != 3'd0) ill = 1'b1;
      end
      OP_LUI: begin
        c.RegWrite = 1'b1;
        c.ALUsrc   = 1'b1;
        c.ALUctrl  = ALU_PASSB;
        c.ImmSrc   = IMM_U;
      end
      OP_AUIPC: begin
        c.RegWrite  = 1'b1;
        c.ALUsrc    = 1'b1;
        c.ImmSrc    = IMM_U;
        c.ResultSrc = RES_PCIMM;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c         = CTRL_BUBBLE;
      c.illegal = 1'b1;
    end
    ctrl_o = c;
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control path of the 5-stage RV32I pipeline.
// Decodes in ID, carries control through ID/EX, EX/MEM, MEM/WB, resolves
// branches in EX from Flags_i, and produces forwarding selects, load-use
// stalls and flushes. stall_ext_i freezes every control register.
// Ports: clk_i/rst_ni; Instr_i, Flags_i, stall_ext_i in; ImmSrc_o (ID),
// ex_* (EX), PCsrc_o, ForwardA/B_o, mem_* (MEM), wb_* (WB),
// StallF/StallD/FlushD/FlushE_o hazard controls, illegal_o (EX).
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 5,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          Instr_i,
  input  logic [2:0]           Flags_i,
  input  logic                 stall_ext_i,
  output logic [2:0]           ImmSrc_o,
  output logic [ALUCTRL_W-1:0] ex_ALUctrl_o,
  output logic                 ex_ALUsrc_o,
  output logic [2:0]           ex_funct3_o,
  output logic [1:0]           PCsrc_o,
  output logic [1:0]           ForwardA_o,
  output logic [1:0]           ForwardB_o,
  output logic                 mem_MemWrite_o,
  output logic [2:0]           mem_funct3_o,
  output logic                 wb_RegWrite_o,
  output logic [1:0]           wb_ResultSrc_o,
  output logic [REG_AW-1:0]    wb_rd_o,
  output logic                 StallF_o,
  output logic                 StallD_o,
  output logic                 FlushD_o,
  output logic                 FlushE_o,
  output logic                 illegal_o
);

  ctrl_t     dec;
  ctrl_t     id_ex_q, id_ex_d;
  mem_ctrl_t ex_mem_q, ex_mem_d;
  wb_ctrl_t  mem_wb_q, mem_wb_d;
  // Low until the first edge after reset release; keeps the combinational
  // outputs quiet for that window as well
  logic      run_q;

  control_decoder #(.SUPPORT_M(SUPPORT_M)) u_dec (
    .instr_i (Instr_i),
    .ctrl_o  (dec)
  );

  // ---- EX: branch resolution ----
  logic zero, gt, gtu, br_taken;
  assign {zero, gt, gtu} = Flags_i;

  always_comb begin
    case (id_ex_q.funct3)
      3'd0:    br_taken = zero;
      3'd1:    br_taken = !zero;
      3'd4:    br_taken = !gt && !zero;
      3'd5:    br_taken = gt || zero;
      3'd6:    br_taken = !gtu && !zero;
      3'd7:    br_taken = gtu || zero;
      default: br_taken = 1'b0;
    endcase
  end

  pc_src_e pc_src;
  always_comb begin
    pc_src = PC_PLUS4;
    if (id_ex_q.jalr)                                         pc_src = PC_RS1IMM;
    else if (id_ex_q.jump || (id_ex_q.branch && br_taken))    pc_src = PC_IMM;
  end

  // ---- hazards ----
  logic redirect, load_use, flush_e, flush_d, stall_fd;
  assign redirect = (pc_src != PC_PLUS4);
  assign load_use = id_ex_q.RegWrite && id_ex_q.ResultSrc == RES_MEM && id_ex_q.rd != '0 &&
                    ((dec.use_rs1 && dec.rs1 == id_ex_q.rd) ||
                     (dec.use_rs2 && dec.rs2 == id_ex_q.rd));
  // redirect squashes the ID instruction anyway, so it overrides the stall
  assign flush_e  = !stall_ext_i && (redirect || load_use);
  assign flush_d  = !stall_ext_i && redirect;
  assign stall_fd = stall_ext_i || (load_use && !redirect);

  // ---- forwarding ----
  fwd_e fwd_a, fwd_b;
  assign fwd_a = fwd_sel(id_ex_q.use_rs1, id_ex_q.rs1, ex_mem_q.RegWrite, ex_mem_q.rd,
                         mem_wb_q.RegWrite, mem_wb_q.rd);
  assign fwd_b = fwd_sel(id_ex_q.use_rs2, id_ex_q.rs2, ex_mem_q.RegWrite, ex_mem_q.rd,
                         mem_wb_q.RegWrite, mem_wb_q.rd);

  // ---- pipeline registers ----
  always_comb begin
    id_ex_d            = flush_e ? CTRL_BUBBLE : dec;
    ex_mem_d.RegWrite  = id_ex_q.RegWrite;
    ex_mem_d.MemWrite  = id_ex_q.MemWrite;
    ex_mem_d.ResultSrc = id_ex_q.ResultSrc;
    ex_mem_d.funct3    = id_ex_q.funct3;
    ex_mem_d.rd        = id_ex_q.rd;
    mem_wb_d.RegWrite  = ex_mem_q.RegWrite;
    mem_wb_d.ResultSrc = ex_mem_q.ResultSrc;
    mem_wb_d.rd        = ex_mem_q.rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_ex_q  <= CTRL_BUBBLE;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (!stall_ext_i) begin
        id_ex_q  <= id_ex_d;
        ex_mem_q <= ex_mem_d;
        mem_wb_q <= mem_wb_d;
      end
    end
  end

  // ImmSrc is only needed in ID; its EX copy is carried for the full bundle
  logic ex_unused;
  assign ex_unused = ^id_ex_q.ImmSrc;

  // ---- outputs ----
  assign ImmSrc_o       = run_q ? dec.ImmSrc : IMM_I;
  assign ex_ALUctrl_o   = ALUCTRL_W'(id_ex_q.ALUctrl);
  assign ex_ALUsrc_o    = id_ex_q.ALUsrc;
  assign ex_funct3_o    = id_ex_q.funct3;
  assign illegal_o      = id_ex_q.illegal;
  assign PCsrc_o        = run_q ? pc_src : PC_PLUS4;
  assign ForwardA_o     = run_q ? fwd_a : FWD_RF;
  assign ForwardB_o     = run_q ? fwd_b : FWD_RF;
  assign mem_MemWrite_o = ex_mem_q.MemWrite;
  assign mem_funct3_o   = ex_mem_q.funct3;
  assign wb_RegWrite_o  = mem_wb_q.RegWrite;
  assign wb_ResultSrc_o = mem_wb_q.ResultSrc;
  assign wb_rd_o        = REG_AW'(mem_wb_q.rd);
  assign StallF_o       = run_q && stall_fd;
  assign StallD_o       = run_q && stall_fd;
  assign FlushD_o       = run_q && flush_d;
  assign FlushE_o       = run_q && flush_e;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: a decode table run through a
// scoreboard (ID/EX/WB expectations queued at issue), then hand sequences
// for forwarding, load-use, branches, jalr, external stall, M-ext, reset.
module tb_pipelined_control_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = NOP;
  logic [2:0]  flags = 3'b000;
  logic        stall = 1'b0;

  logic [2:0] d_imm, m_imm;
  logic [4:0] d_alu, m_alu;
  logic       d_src, m_src;
  logic [2:0] d_f3, m_f3;
  logic [1:0] d_pc, m_pc, d_fa, m_fa, d_fb, m_fb;
  logic       d_mw, m_mw;
  logic [2:0] d_mf3, m_mf3;
  logic       d_rw, m_rw;
  logic [1:0] d_rs, m_rs;
  logic [4:0] d_rd, m_rd;
  logic       d_sf, m_sf, d_sd, m_sd, d_fd, m_fd, d_fe, m_fe, d_ill, m_ill;

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_AW(5), .ALUCTRL_W(5), .SUPPORT_M(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .Instr_i(instr), .Flags_i(flags), .stall_ext_i(stall),
    .ImmSrc_o(d_imm), .ex_ALUctrl_o(d_alu), .ex_ALUsrc_o(d_src), .ex_funct3_o(d_f3),
    .PCsrc_o(d_pc), .ForwardA_o(d_fa), .ForwardB_o(d_fb), .mem_MemWrite_o(d_mw),
    .mem_funct3_o(d_mf3), .wb_RegWrite_o(d_rw), .wb_ResultSrc_o(d_rs), .wb_rd_o(d_rd),
    .StallF_o(d_sf), .StallD_o(d_sd), .FlushD_o(d_fd), .FlushE_o(d_fe), .illegal_o(d_ill));

  pipelined_control_unit #(.REG_AW(5), .ALUCTRL_W(5), .SUPPORT_M(1'b1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .Instr_i(instr), .Flags_i(flags), .stall_ext_i(stall),
    .ImmSrc_o(m_imm), .ex_ALUctrl_o(m_alu), .ex_ALUsrc_o(m_src), .ex_funct3_o(m_f3),
    .PCsrc_o(m_pc), .ForwardA_o(m_fa), .ForwardB_o(m_fb), .mem_MemWrite_o(m_mw),
    .mem_funct3_o(m_mf3), .wb_RegWrite_o(m_rw), .wb_ResultSrc_o(m_rs), .wb_rd_o(m_rd),
    .StallF_o(m_sf), .StallD_o(m_sd), .FlushD_o(m_fd), .FlushE_o(m_fe), .illegal_o(m_ill));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- decode table ----
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm;
    logic [4:0]  alu;
    logic        src;
    logic [2:0]  f3;
    logic        ill;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic setv(input int i, input logic [31:0] in, input logic [2:0] imm,
                      input logic [4:0] alu, input logic src, input logic [2:0] f3,
                      input logic ill, input logic rw, input logic [1:0] rs, input logic [4:0] rd);
    vt[i].instr = in; vt[i].imm = imm; vt[i].alu = alu; vt[i].src = src; vt[i].f3 = f3;
    vt[i].ill = ill; vt[i].rw = rw; vt[i].rs = rs; vt[i].rd = rd;
  endtask

  // ---- scoreboard: kind 0 = ID, 1 = EX, 2 = WB ----
  typedef struct { int cyc; int kind; int idx; } sb_t;
  sb_t sbq[$];
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    sb_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      case (e.kind)
        0: check($sformatf("v%0d_ImmSrc", e.idx), 64'(d_imm), 64'(vt[e.idx].imm));
        1: begin
          check($sformatf("v%0d_ALUctrl", e.idx), 64'(d_alu), 64'(vt[e.idx].alu));
          check($sformatf("v%0d_ALUsrc", e.idx), 64'(d_src), 64'(vt[e.idx].src));
          check($sformatf("v%0d_funct3", e.idx), 64'(d_f3), 64'(vt[e.idx].f3));
          check($sformatf("v%0d_illegal", e.idx), 64'(d_ill), 64'(vt[e.idx].ill));
        end
        default: begin
          check($sformatf("v%0d_wbRegWrite", e.idx), 64'(d_rw), 64'(vt[e.idx].rw));
          check($sformatf("v%0d_wbResultSrc", e.idx), 64'(d_rs), 64'(vt[e.idx].rs));
          check($sformatf("v%0d_wbrd", e.idx), 64'(d_rd), 64'(vt[e.idx].rd));
        end
      endcase
    end
  end

  // Drive x into ID just after the edge, return at the following negedge
  task automatic cyc_in(input logic [31:0] x);
    @(posedge clk); #1;
    instr = x;
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, d_imm, d_alu, d_src, d_f3, d_pc, d_fa, d_fb, d_mw, d_mf3, d_rw, d_rs,
            d_rd, d_sf, d_sd, d_fd, d_fe, d_ill};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    setv(0,  32'h002081B3, 3'd0, 5'd0,  1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 5'd3);  // add
    setv(1,  32'h40118233, 3'd0, 5'd1,  1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 5'd4);  // sub
    setv(2,  32'h0000A283, 3'd0, 5'd0,  1'b1, 3'd2, 1'b0, 1'b1, 2'd1, 5'd5);  // lw
    setv(3,  32'h0020A023, 3'd1, 5'd0,  1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 5'd0);  // sw
    setv(4,  32'h123453B7, 3'd3, 5'd10, 1'b1, 3'd5, 1'b0, 1'b1, 2'd0, 5'd7);  // lui
    setv(5,  32'h00001417, 3'd3, 5'd0,  1'b1, 3'd1, 1'b0, 1'b1, 2'd3, 5'd8);  // auipc
    setv(6,  32'hFFF0C493, 3'd0, 5'd5,  1'b1, 3'd4, 1'b0, 1'b1, 2'd0, 5'd9);  // xori
    setv(7,  32'h4030D513, 3'd0, 5'd7,  1'b1, 3'd5, 1'b0, 1'b1, 2'd0, 5'd10); // srai
    setv(8,  32'h022081B3, 3'd0, 5'd0,  1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 5'd0);  // mul, no M
    setv(9,  32'h0000007F, 3'd0, 5'd0,  1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 5'd0);  // bad opcode
    setv(10, 32'h0020F5B3, 3'd0, 5'd9,  1'b0, 3'd7, 1'b0, 1'b1, 2'd0, 5'd11); // and
    setv(11, 32'h0020A633, 3'd0, 5'd3,  1'b0, 3'd2, 1'b0, 1'b1, 2'd0, 5'd12); // slt
    setv(12, 32'h010000EF, 3'd4, 5'd0,  1'b0, 3'd0, 1'b0, 1'b1, 2'd2, 5'd1);  // jal
    setv(13, 32'h40109093, 3'd0, 5'd0,  1'b0, 3'd0, 1'b1, 1'b0, 2'd0, 5'd0);  // slli bad f7

    // reset state, with inputs that would otherwise drive outputs
    instr = 32'h123453B7; stall = 1'b1;
    #12;
    check("reset_all_outputs", all_outs(), 64'd0);
    stall = 1'b0; instr = NOP;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // decode table through the scoreboard
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      instr = vt[i].instr;
      sbq.push_back('{cyc, 0, i});
      sbq.push_back('{cyc + 1, 1, i});
      sbq.push_back('{cyc + 3, 2, i});
      repeat (3) begin @(posedge clk); #1; instr = NOP; end
    end
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);

    // forwarding: MEM then WB distance
    cyc_in(32'h002081B3); cyc_in(32'h40118233); cyc_in(NOP);
    check("fwdA_mem", 64'(d_fa), 64'd2);
    check("sub_ALUctrl", 64'(d_alu), 64'd1);
    check("fwdB_none", 64'(d_fb), 64'd0);
    cyc_in(32'h002081B3); cyc_in(NOP); cyc_in(32'h40118233); cyc_in(NOP);
    check("fwdA_wb", 64'(d_fa), 64'd1);

    // load-use
    cyc_in(32'h0000A283); cyc_in(32'h00528333);
    check("lu_StallF", 64'(d_sf), 64'd1);
    check("lu_StallD", 64'(d_sd), 64'd1);
    check("lu_FlushE", 64'(d_fe), 64'd1);
    check("lu_FlushD", 64'(d_fd), 64'd0);
    cyc_in(32'h00528333);
    check("lu_one_cycle", 64'({d_sf, d_sd, d_fe}), 64'd0);
    cyc_in(NOP);
    check("lu_fwdA", 64'(d_fa), 64'd1);
    check("lu_fwdB", 64'(d_fb), 64'd1);
    check("lu_wbResultSrc", 64'(d_rs), 64'd1);
    check("lu_wbrd", 64'(d_rd), 64'd5);

    // branches
    flags = 3'b100; cyc_in(32'h00208463); cyc_in(NOP);
    check("beq_taken_pc", 64'(d_pc), 64'd1);
    check("beq_taken_flush", 64'({d_fd, d_fe, d_sf}), 64'b110);
    cyc_in(NOP);
    check("beq_flush_one_cycle", 64'({d_pc, d_fd, d_fe}), 64'd0);
    flags = 3'b010; cyc_in(32'h00208463); cyc_in(NOP);
    check("beq_not_taken", 64'({d_pc, d_fd, d_fe}), 64'd0);
    flags = 3'b000; cyc_in(32'h0020C463); cyc_in(NOP);
    check("blt_taken", 64'(d_pc), 64'd1);
    cyc_in(32'h0020D463); cyc_in(NOP);
    check("bge_not_taken", 64'(d_pc), 64'd0);
    flags = 3'b001; cyc_in(32'h0020E463); cyc_in(NOP);
    check("bltu_not_taken", 64'(d_pc), 64'd0);
    flags = 3'b000;

    // jalr with a load-use pair behind it
    cyc_in(32'h000280E7); cyc_in(32'h0000A283);
    check("jalr_pc", 64'(d_pc), 64'd2);
    check("jalr_flush", 64'({d_fd, d_fe, d_sf, d_sd}), 64'b1100);
    cyc_in(32'h00528333);
    check("jalr_lw_squashed", 64'({d_sf, d_fe}), 64'd0);
    cyc_in(NOP);
    check("jalr_wbResultSrc", 64'(d_rs), 64'd2);
    check("jalr_wbrd", 64'(d_rd), 64'd1);

    // external stall over a taken branch
    flags = 3'b100; cyc_in(32'h00208463);
    @(posedge clk); #1; instr = NOP; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_hold", k),
            64'({d_pc, d_sf, d_sd, d_fd, d_fe, d_alu}), 64'({2'd1, 4'b1100, 5'd1}));
    end
    @(posedge clk); #1; stall = 1'b0;
    @(negedge clk);
    check("stall_release_flush", 64'({d_pc, d_fd, d_fe, d_sf}), 64'({2'd1, 3'b110}));
    cyc_in(NOP);
    check("stall_after_flush", 64'({d_pc, d_fd}), 64'd0);
    flags = 3'b000;

    // M extension
    cyc_in(32'h022081B3); cyc_in(NOP);
    check("mul_M_ALUctrl", 64'(m_alu), 64'd14);
    check("mul_M_legal", 64'(m_ill), 64'd0);
    check("mul_noM_illegal", 64'(d_ill), 64'd1);
    cyc_in(32'h0220B1B3);
    check("illegal_pulse_end", 64'(d_ill), 64'd0);
    cyc_in(NOP);
    check("mulhu_M_ALUctrl", 64'(m_alu), 64'd17);

    // reset with a store in MEM
    cyc_in(32'h0020A023); cyc_in(NOP); cyc_in(NOP);
    check("store_in_mem", 64'(d_mw), 64'd1);
    #2; rst_n = 1'b0; instr = 32'h123453B7; stall = 1'b1;
    #1;
    check("rst_async_memwrite", 64'(d_mw), 64'd0);
    check("rst_async_all", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    check("rst_held_all", all_outs(), 64'd0);
    #1; stall = 1'b0; rst_n = 1'b1;
    #1;
    check("rst_release_before_edge", all_outs(), 64'd0);
    @(negedge clk);
    check("rst_after_edge_ImmSrc", 64'(d_imm), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
